// File: rtl/fb_adder_pkg.sv
// Shared constants for the registered 4-bit ripple-carry adder.
package fb_adder_pkg;
  localparam int                  FB_WIDTH    = 4;
  localparam logic [FB_WIDTH-1:0] FB_RST_SUM  = 4'b0000;
  localparam logic                FB_RST_COUT = 1'b0;
endpackage

// File: rtl/four_bit_adder_full_adder.sv
// One-bit full adder: a single stage of the ripple chain. Purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);
endmodule

// File: rtl/four_bit_adder.sv
// Registered 4-bit ripple-carry adder with scalar pins. The result appears one cycle after
// the operands are sampled; there is no enable or handshake, so one result is taken every cycle.
module four_bit_adder
  import fb_adder_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a3,
  input  logic a2,
  input  logic a1,
  input  logic a0,
  input  logic b3,
  input  logic b2,
  input  logic b1,
  input  logic b0,
  input  logic cin,
  output logic s3,
  output logic s2,
  output logic s1,
  output logic s0,
  output logic cout
);
  logic [FB_WIDTH-1:0] w_a;
  logic [FB_WIDTH-1:0] w_b;
  logic [FB_WIDTH-1:0] w_s;
  logic [FB_WIDTH:0]   w_c;
  logic [FB_WIDTH-1:0] r_sum;
  logic                r_cout;

  assign w_a    = {a3, a2, a1, a0};
  assign w_b    = {b3, b2, b1, b0};
  assign w_c[0] = cin;

  for (genvar i = 0; i < FB_WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a  (w_a[i]),
      .b  (w_b[i]),
      .ci (w_c[i]),
      .s  (w_s[i]),
      .co (w_c[i+1])
    );
  end

  // Reset wins over whatever operands are present at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum  <= FB_RST_SUM;
      r_cout <= FB_RST_COUT;
    end else begin
      r_sum  <= w_s;
      r_cout <= w_c[FB_WIDTH];
    end
  end

  assign {s3, s2, s1, s0} = r_sum;
  assign cout             = r_cout;
endmodule

// File: tb/tb_four_bit_adder.sv
// Bench for four_bit_adder: directed and random operands checked against plain A + B + cin.
module tb_four_bit_adder;
  logic clk;
  logic rst_n;
  logic a3, a2, a1, a0;
  logic b3, b2, b1, b0;
  logic cin;
  logic s3, s2, s1, s0;
  logic cout;
  logic [4:0] obs;

  int   n_pass;
  int   n_total;
  logic [4:0] prev_exp;
  bit   prev_valid;

  four_bit_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a3    (a3),
    .a2    (a2),
    .a1    (a1),
    .a0    (a0),
    .b3    (b3),
    .b2    (b2),
    .b1    (b1),
    .b0    (b0),
    .cin   (cin),
    .s3    (s3),
    .s2    (s2),
    .s1    (s1),
    .s0    (s0),
    .cout  (cout)
  );

  assign obs = {cout, s3, s2, s1, s0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, confirm the output holds until the edge, then check the new result.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic ci,
                      input logic rn, input string tag);
    logic [4:0] exp;
    {a3, a2, a1, a0} = a;
    {b3, b2, b1, b0} = b;
    cin   = ci;
    rst_n = rn;
    exp   = rn ? 5'(int'(a) + int'(b) + int'(ci)) : 5'd0;
    #1;
    if (prev_valid) check({tag, " hold"}, prev_exp);
    @(posedge clk);
    #1;
    check(tag, exp);
    prev_exp   = exp;
    prev_valid = 1'b1;
  endtask

  initial begin
    logic [3:0] ra, rb;
    logic       rc, rr;
    n_pass     = 0;
    n_total    = 0;
    prev_valid = 1'b0;
    rst_n      = 1'b0;
    {a3, a2, a1, a0, b3, b2, b1, b0, cin} = '0;
    @(negedge clk);

    // Reset overrides a maximal operand set, then release.
    step(4'hF, 4'hF, 1'b1, 1'b0, "reset edge1");
    step(4'hF, 4'hF, 1'b1, 1'b0, "reset edge2");
    step(4'hF, 4'hF, 1'b1, 1'b1, "release 15+15+1");

    // Exhaustive sweep, cin = 0.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        step(4'(ia), 4'(ib), 1'b0, 1'b1, $sformatf("sweep %0d+%0d", ia, ib));
      end
    end

    // Spot checks with explicit constants.
    step(4'h0, 4'h1, 1'b0, 1'b1, "spot 0+1");
    check("spot 0+1 const", 5'b00001);
    step(4'h7, 4'h9, 1'b0, 1'b1, "spot 7+9");
    check("spot 7+9 const", 5'b10000);
    step(4'hF, 4'hF, 1'b0, 1'b1, "spot 15+15");
    check("spot 15+15 const", 5'b11110);

    // Carry-in cases.
    step(4'hF, 4'h0, 1'b1, 1'b1, "cin F+0+1");
    check("cin F+0+1 const", 5'b10000);
    step(4'h5, 4'hA, 1'b0, 1'b1, "cin 5+A+0");
    check("cin 5+A+0 const", 5'b01111);

    // Full carry ripple toggling.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(4'hF, 4'h0, 1'b1, 1'b1, "ripple F+0+1");
      else            step(4'h0, 4'h0, 1'b0, 1'b1, "ripple 0+0+0");
    end

    // Reset asserted mid-stream discards the in-flight result.
    step(4'h8, 4'h8, 1'b0, 1'b1, "mid 8+8");
    check("mid 8+8 const", 5'b10000);
    step(4'h8, 4'h8, 1'b0, 1'b0, "mid reset");
    check("mid reset const", 5'b00000);
    step(4'h3, 4'h4, 1'b0, 1'b1, "mid 3+4");
    check("mid 3+4 const", 5'b00111);

    // Back-to-back random vectors.
    for (int i = 0; i < 16; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      step(ra, rb, rc, 1'b1, $sformatf("b2b %0d: %0d+%0d+%0d", i, ra, rb, rc));
    end

    // Random operands with occasional reset.
    for (int i = 0; i < 64; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 1'($urandom);
      rr = ($urandom_range(0, 7) != 0);
      step(ra, rb, rc, rr, $sformatf("rand %0d: %0d+%0d+%0d rst_n=%0d", i, ra, rb, rc, rr));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
